// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_REQ,
        M_WAIT,
        M_FAULT
    } mem_state_t;

    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction memory req/gnt/rvalid bus.
// master = fetch side (drives req/addr), slave = memory side.
interface fetch_sequencer_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req;
    logic [PC_WIDTH-1:0]   addr;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_sequencer_pc_next.sv
// pc_next: combinational next-fetch-address selection.
// Flush target beats branch target beats sequential PC+4.
// Without FETCH_ALIGN_CHECK_EN the low two address bits are forced to zero.
module pc_next
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] instr_pc,
    input  logic [PC_WIDTH-1:0] imm_op,
    input  logic                pc_src,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] flush_pc,
    output logic [PC_WIDTH-1:0] addr,
    output logic                misaligned
);
    logic [PC_WIDTH-1:0] raw;

    // Select target; additions wrap modulo 2^PC_WIDTH.
    always_comb begin
        raw = instr_pc + PC_WIDTH'(PC_INCR);
        if (flush) begin
            raw = flush_pc;
        end else if (pc_src) begin
            raw = instr_pc + imm_op;
        end
        misaligned = |raw[1:0];
`ifdef FETCH_ALIGN_CHECK_EN
        addr = raw;
`else
        addr = {raw[PC_WIDTH-1:2], 2'b00};
`endif
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues one instruction-memory request at a
// time and presents each fetched word to decode via valid/ready.
// Optional: FETCH_ALIGN_CHECK_EN adds fetch_fault and the M_FAULT lockout.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_sequencer_if.master     imem,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]   instr_pc,
    input  logic                  pc_src,
    input  logic [PC_WIDTH-1:0]   imm_op,
    input  logic                  flush,
    input  logic [PC_WIDTH-1:0]   flush_pc,
    input  logic                  halt
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                  fetch_fault
`endif
);
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    mem_state_t          state;
    logic                squash;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] tgt_addr;
    logic                tgt_misaligned;
    logic                accept;
    logic                fault_hit;

    assign accept    = instr_valid & instr_ready;
    // Without the check the target is already aligned, so this is constant 0.
    assign fault_hit = ALIGN_CHECK && tgt_misaligned;

    pc_next #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .instr_pc   (instr_pc),
        .imm_op     (imm_op),
        .pc_src     (pc_src),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .addr       (tgt_addr),
        .misaligned (tgt_misaligned)
    );

    // Memory FSM plus registered request and decode-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= M_IDLE;
            squash      <= 1'b0;
            next_pc     <= RESET_PC;
            imem.req    <= 1'b0;
            imem.addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (flush) begin
            instr_valid <= 1'b0;
            next_pc     <= tgt_addr;
            if (fault_hit) begin
                state    <= M_FAULT;
                imem.req <= 1'b0;
                squash   <= 1'b0;
            end else begin
                case (state)
                    M_REQ: begin
                        imem.req <= 1'b0;
                        if (imem.gnt) begin
                            state  <= M_WAIT;
                            squash <= 1'b1;
                        end else begin
                            state <= M_IDLE;
                        end
                    end
                    M_WAIT: begin
                        if (imem.rvalid) begin
                            state  <= M_IDLE;
                            squash <= 1'b0;
                        end else begin
                            squash <= 1'b1;
                        end
                    end
                    M_FAULT: state <= M_IDLE;
                    default: ;
                endcase
            end
        end else begin
            if (accept) begin
                instr_valid <= 1'b0;
                next_pc     <= tgt_addr;
            end
            case (state)
                M_IDLE: begin
                    if (accept && fault_hit) begin
                        state <= M_FAULT;
                    end else if (!halt && (!instr_valid || accept)) begin
                        imem.req  <= 1'b1;
                        imem.addr <= accept ? tgt_addr : next_pc;
                        state     <= M_REQ;
                    end
                end
                M_REQ: begin
                    if (imem.gnt) begin
                        imem.req <= 1'b0;
                        state    <= M_WAIT;
                    end
                end
                M_WAIT: begin
                    if (imem.rvalid) begin
                        if (squash) begin
                            squash <= 1'b0;
                        end else begin
                            instr       <= imem.rdata;
                            instr_pc    <= imem.addr;
                            instr_valid <= 1'b1;
                        end
                        state <= M_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = (state == M_FAULT);
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed-vector bench for fetch_sequencer.
// Covers FETCH_ALIGN_CHECK_EN behaviour when that macro is defined.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        pc_src;
    logic [31:0] imm_op;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halt;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int errors = 0;
    int checks = 0;

    fetch_sequencer_if #(.PC_WIDTH(32), .DATA_WIDTH(32)) imem_bus ();

    fetch_sequencer #(
        .PC_WIDTH   (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_src      (pc_src),
        .imm_op      (imm_op),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .halt        (halt)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a request, check its address, grant it and return word.
    task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
        for (int i = 0; i < 8 && !imem_bus.req; i++) tick();
        check({tag, "_req"}, imem_bus.req, 1);
        check({tag, "_addr"}, imem_bus.addr, exp_addr);
        imem_bus.gnt = 1'b1;
        tick();
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = word;
        tick();
        imem_bus.rvalid = 1'b0;
        check({tag, "_valid"}, instr_valid, 1);
        check({tag, "_instr"}, instr, word);
        check({tag, "_pc"}, instr_pc, exp_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_ready = 1'b0; pc_src = 1'b0; imm_op = '0;
        flush = 1'b0; flush_pc = '0; halt = 1'b0;
        imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
        tick(); tick();
        check("rst_req", imem_bus.req, 0);
        check("rst_addr", imem_bus.addr, 32'h0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_fault", fetch_fault, 0);
`endif

        // First fetch, ready held high: accept re-issues at PC+4.
        rst = 1'b0;
        instr_ready = 1'b1;
        tick();
        do_fetch("first", 32'h0, 32'h0050_0093);
        tick();
        instr_ready = 1'b0;
        check("seq_req", imem_bus.req, 1);
        check("seq_addr", imem_bus.addr, 32'h4);
        check("seq_valid", instr_valid, 0);
        do_fetch("second", 32'h4, 32'h11);

        // Flush while idle with an instruction pending, then taken branch.
        flush = 1'b1; flush_pc = 32'h10;
        tick();
        flush = 1'b0;
        check("fl_idle_valid", instr_valid, 0);
        do_fetch("br1", 32'h10, 32'h22);
        instr_ready = 1'b1; pc_src = 1'b1; imm_op = 32'hFFFF_FFF8;
        tick();
        instr_ready = 1'b0; pc_src = 1'b0; imm_op = '0;
        check("br_taken_addr", imem_bus.addr, 32'h8);
        do_fetch("br_tgt", 32'h8, 32'h33);
        flush = 1'b1; flush_pc = 32'h10;
        tick();
        flush = 1'b0;
        do_fetch("br2", 32'h10, 32'h22);
        instr_ready = 1'b1; imm_op = 32'hFFFF_FFF8;
        tick();
        instr_ready = 1'b0; imm_op = '0;
        check("br_nt_addr", imem_bus.addr, 32'h14);

        // Backpressure: output held, no new request.
        do_fetch("bp", 32'h14, 32'h44);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_instr", instr, 32'h44);
            check("bp_pc", instr_pc, 32'h14);
            check("bp_req", imem_bus.req, 0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("bp_rel_req", imem_bus.req, 1);
        check("bp_rel_addr", imem_bus.addr, 32'h18);
        tick();
        check("hold_req", imem_bus.req, 1);
        check("hold_addr", imem_bus.addr, 32'h18);
        imem_bus.gnt = 1'b1;
        tick();
        imem_bus.gnt = 1'b0;
        check("gnt_drop_req", imem_bus.req, 0);
        tick();
        check("wait_req", imem_bus.req, 0);

        // Flush in M_WAIT: the in-flight response is dropped.
        flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        check("flw_valid", instr_valid, 0);
        check("flw_req", imem_bus.req, 0);
        imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'hDEAD_BEEF;
        tick();
        imem_bus.rvalid = 1'b0;
        check("flw_drop_valid", instr_valid, 0);
        tick();
        check("flw_re_req", imem_bus.req, 1);
        check("flw_re_addr", imem_bus.addr, 32'h100);

        // Flush in M_REQ without gnt: withdraw, then re-request.
        flush = 1'b1; flush_pc = 32'h200;
        tick();
        flush = 1'b0;
        check("flr_withdraw", imem_bus.req, 0);
        tick();
        check("flr_re_req", imem_bus.req, 1);
        check("flr_re_addr", imem_bus.addr, 32'h200);

        // Flush coincident with gnt: one response squashed.
        flush = 1'b1; flush_pc = 32'h300; imem_bus.gnt = 1'b1;
        tick();
        flush = 1'b0; imem_bus.gnt = 1'b0;
        check("flg_req", imem_bus.req, 0);
        imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'hBAD;
        tick();
        imem_bus.rvalid = 1'b0;
        check("flg_drop_valid", instr_valid, 0);
        tick();
        check("flg_re_req", imem_bus.req, 1);
        check("flg_re_addr", imem_bus.addr, 32'h300);
        do_fetch("after_sq", 32'h300, 32'h55);

        // Halt blocks issue only.
        halt = 1'b1; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("halt_valid", instr_valid, 0);
        check("halt_req", imem_bus.req, 0);
        tick();
        check("halt_req2", imem_bus.req, 0);
        halt = 1'b0;
        tick();
        check("unhalt_req", imem_bus.req, 1);
        check("unhalt_addr", imem_bus.addr, 32'h304);

        // Stray rvalid while in M_REQ is ignored.
        imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'hFF;
        tick();
        imem_bus.rvalid = 1'b0;
        check("stray_valid", instr_valid, 0);
        check("stray_req", imem_bus.req, 1);

        // Address wrap at the top of the space.
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        check("wrap_withdraw", imem_bus.req, 0);
        do_fetch("wrap", 32'hFFFF_FFFC, 32'h66);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("wrap_addr", imem_bus.addr, 32'h0);

        // Branch to a misaligned target (0 + 6).
        do_fetch("mis", 32'h0, 32'h77);
        instr_ready = 1'b1; pc_src = 1'b1; imm_op = 32'h6;
        tick();
        instr_ready = 1'b0; pc_src = 1'b0; imm_op = '0;
`ifdef FETCH_ALIGN_CHECK_EN
        check("fault_set", fetch_fault, 1);
        check("fault_req", imem_bus.req, 0);
        tick(); tick();
        check("fault_hold", fetch_fault, 1);
        check("fault_req2", imem_bus.req, 0);
        flush = 1'b1; flush_pc = 32'h200;
        tick();
        flush = 1'b0;
        check("fault_clr", fetch_fault, 0);
        tick();
        check("fault_re_req", imem_bus.req, 1);
        check("fault_re_addr", imem_bus.addr, 32'h200);
`else
        check("align_req", imem_bus.req, 1);
        check("align_addr", imem_bus.addr, 32'h4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
